wlan_transmitter: RTL and testbench

- Serial baseband bit-stream transmitter modelled on the 802.11a coding chain.
- On a Start pulse it emits one fixed-length frame of 576 coded bits on a single serial output.
- Frame content: a 96-bit alternating-pattern preamble, then 192 payload bits taken from the serial Input. Payload is scrambled; every frame bit is convolutionally encoded at rate 1/2.
- Sits between the MAC-side serial data source and the modulator/DAC front end.

---
 rtl/wlan_transmitter_if.sv | 19 +
 rtl/wlan_transmitter.sv | 105 ++++++++++
 tb/tb_wlan_transmitter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wlan_transmitter_if.sv
// Serial frame request, payload input and coded bit stream of the WLAN transmitter.
// The master side is the MAC data source / bench, the slave side is the transmitter.
interface wlan_transmitter_if;
    logic start;
    logic payload_dat;
    logic coded_dat;

    modport master (
        output start,
        output payload_dat,
        input  coded_dat
    );

    modport slave (
        input  start,
        input  payload_dat,
        output coded_dat
    );
endinterface

// File: rtl/wlan_transmitter.sv
// Emits one 576-bit rate-1/2 K=7 coded frame (alternating preamble + scrambled payload) per start.
// Latency: first coded bit one cycle after the start edge, then one coded bit per cycle.
// No backpressure: start is ignored while busy, payload_dat is sampled blindly at phase 0.
module wlan_transmitter #(
    parameter int          PREAMBLE_BITS  = 96,
    parameter int          PAYLOAD_BITS   = 192,
    parameter logic [6:0]  SCRAMBLER_SEED = 7'b1111111
) (
    input  logic               clk,
    input  logic               rst_n,
    wlan_transmitter_if.slave  tx
);

    localparam int FRAME_SLOTS = PREAMBLE_BITS + PAYLOAD_BITS;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    localparam logic [SLOT_W-1:0] LAST_PRE_SLOT   = SLOT_W'(PREAMBLE_BITS - 1);
    localparam logic [SLOT_W-1:0] LAST_FRAME_SLOT = SLOT_W'(FRAME_SLOTS - 1);

    // Generator masks over {current bit, history[5:0]}; bit 6 is the weight-64 tap.
    localparam logic [6:0] GEN_A = 7'o133;
    localparam logic [6:0] GEN_B = 7'o171;

    // History as if the frame were preceded by ...1,0 so the preamble codes to 1100...
    localparam logic [5:0] HIST_INIT = 6'b010101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic                phase;
    logic [5:0]          hist;
    logic [6:0]          scr;
    logic                cur_bit;
    logic                coded_q;

    logic                scr_bit;
    logic                src_bit;
    logic [6:0]          window_a;
    logic [6:0]          window_b;

    always_comb begin
        scr_bit  = scr[6] ^ scr[3];
        src_bit  = (state == PAYLOAD) ? (tx.payload_dat ^ scr_bit) : ~slot[0];
        window_a = {src_bit, hist};
        window_b = {cur_bit, hist};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            slot    <= '0;
            phase   <= 1'b0;
            hist    <= '0;
            scr     <= '0;
            cur_bit <= 1'b0;
            coded_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    coded_q <= 1'b0;
                    if (tx.start) begin
                        state   <= PREAMBLE;
                        slot    <= '0;
                        phase   <= 1'b0;
                        hist    <= HIST_INIT;
                        cur_bit <= 1'b0;
                    end
                end
                default: begin
                    if (!phase) begin
                        coded_q <= ^(window_a & GEN_A);
                        cur_bit <= src_bit;
                        phase   <= 1'b1;
                        if (state == PAYLOAD) begin
                            scr <= {scr[5:0], scr_bit};
                        end
                    end else begin
                        coded_q <= ^(window_b & GEN_B);
                        hist    <= {cur_bit, hist[5:1]};
                        phase   <= 1'b0;
                        if (slot == LAST_FRAME_SLOT) begin
                            state <= IDLE;
                            slot  <= '0;
                        end else begin
                            slot <= slot + SLOT_W'(1);
                            // Scrambler restarts from the seed for every frame's payload.
                            if (slot == LAST_PRE_SLOT) begin
                                state <= PAYLOAD;
                                scr   <= SCRAMBLER_SEED;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign tx.coded_dat = coded_q;

endmodule

// File: tb/tb_wlan_transmitter.sv
// Self-checking bench for wlan_transmitter: random payloads against a frame-level reference model.
module tb_wlan_transmitter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    logic [576:1] got_vec;
    logic [576:1] zero_ref;
    logic         gap_bit;

    always #5 clk = ~clk;

    wlan_transmitter_if tif ();

    wlan_transmitter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx    (tif)
    );

    // Whole-frame reference: uncoded bit list, scrambler as s[n] = s[n-7] ^ s[n-4],
    // then the g0=133 / g1=171 convolution written as explicit delay taps.
    function automatic logic [576:1] model_frame(input logic [191:0] pay);
        bit u [0:293];
        bit s [0:198];
        logic [576:1] f;
        bit d0, d1, d2, d3, d5, d6;
        for (int i = 0; i < 7; i++) s[i] = 1'b1;
        for (int n = 0; n < 192; n++) s[n+7] = s[n] ^ s[n+3];
        for (int i = -6; i < 96; i++) u[i+6] = (i % 2 == 0);
        for (int n = 0; n < 192; n++) u[96+n+6] = pay[n] ^ s[n+7];
        f = '0;
        for (int m = 0; m < 288; m++) begin
            d0 = u[m+6];
            d1 = u[m+5];
            d2 = u[m+4];
            d3 = u[m+3];
            d5 = u[m+1];
            d6 = u[m];
            f[2*m+1] = d0 ^ d2 ^ d3 ^ d5 ^ d6;
            f[2*m+2] = d0 ^ d1 ^ d2 ^ d3 ^ d6;
        end
        return f;
    endfunction

    function automatic int first_diff(input logic [576:1] a, input logic [576:1] b);
        for (int k = 1; k <= 576; k++) if (a[k] !== b[k]) return k;
        return 0;
    endfunction

    function automatic logic [191:0] rand_payload();
        logic [191:0] p;
        for (int i = 0; i < 192; i++) p[i] = 1'($urandom);
        return p;
    endfunction

    // Called at a negedge with the DUT idle; start is accepted on the next posedge.
    task automatic run_frame(input logic [191:0] pay, input bit junk,
                             input int restart_at, input int abort_at);
        int slot;
        tif.start = 1'b1;
        @(negedge clk);
        gap_bit = tif.coded_dat;
        got_vec = '0;
        for (int k = 1; k <= 576; k++) begin
            slot = (k - 1) / 2;
            if (k % 2 == 1)
                tif.payload_dat = (slot >= 96) ? pay[slot-96] : (junk ? 1'($urandom) : 1'b0);
            else if (junk)
                tif.payload_dat = 1'($urandom);
            tif.start = (k == restart_at);
            @(negedge clk);
            got_vec[k] = tif.coded_dat;
            if (k == abort_at) break;
        end
        tif.start = 1'b0;
    endtask

    task automatic check_preamble(input string name);
        logic [192:1] exp_pre;
        for (int k = 1; k <= 192; k++) exp_pre[k] = ((k - 1) % 4 < 2);
        checks++;
        if (got_vec[192:1] !== exp_pre) begin
            fails++;
            $display("FAIL %s_preamble: first differing coded bit %0d, got %b expected 1100 repeated",
                     name, first_diff({384'b0, got_vec[192:1]}, {384'b0, exp_pre}),
                     got_vec[first_diff({384'b0, got_vec[192:1]}, {384'b0, exp_pre})]);
        end
    endtask

    task automatic check_frame(input string name, input logic [191:0] pay);
        logic [576:1] exp;
        int d;
        exp = model_frame(pay);
        d = first_diff(got_vec, exp);
        checks++;
        if (d != 0) begin
            fails++;
            $display("FAIL %s_frame: first mismatch at coded bit %0d, got %b expected %b",
                     name, d, got_vec[d], exp[d]);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        int ones;
        ones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tif.coded_dat !== 1'b0) ones++;
        end
        checks++;
        if (ones != 0) begin
            fails++;
            $display("FAIL %s_idle: %0d non-zero output cycles, expected 0", name, ones);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tif.start = 1'b0;
        tif.payload_dat = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tif.coded_dat !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: coded_dat=%b expected 0", tif.coded_dat);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tif.start = 1'b1;
        @(negedge clk);
        tif.start = 1'b0;
        @(negedge clk);
        checks++;
        if (tif.coded_dat !== 1'b1) begin
            fails++;
            $display("FAIL first_coded_bit: coded_dat=%b expected 1", tif.coded_dat);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tif.coded_dat !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: coded_dat=%b expected 0", tif.coded_dat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("post_reset", 20);
    endtask

    task automatic test_zero_payload();
        run_frame('0, 1'b0, 0, 0);
        checks++;
        if (gap_bit !== 1'b0) begin
            fails++;
            $display("FAIL zero_accept_cycle: coded_dat=%b expected 0", gap_bit);
        end
        check_preamble("zero");
        check_frame("zero", '0);
        zero_ref = got_vec;
        check_idle("zero_end", 10);
    endtask

    task automatic test_pattern();
        logic [191:0] pay;
        int d;
        pay = '0;
        pay[8]  = 1'b1;
        pay[11] = 1'b1;
        run_frame(pay, 1'b0, 0, 0);
        d = first_diff(got_vec, zero_ref);
        checks++;
        if (d != 209) begin
            fails++;
            $display("FAIL pattern_divergence: first difference at coded bit %0d expected 209", d);
        end
        check_frame("pattern", pay);
        check_idle("pattern_end", 4);
    endtask

    task automatic test_back_to_back();
        logic [191:0] pay;
        for (int f = 0; f < 3; f++) begin
            pay = rand_payload();
            run_frame(pay, 1'b1, 0, 0);
            checks++;
            if (gap_bit !== 1'b0) begin
                fails++;
                $display("FAIL b2b_accept_cycle_%0d: coded_dat=%b expected 0", f, gap_bit);
            end
            check_preamble("b2b");
            check_frame("b2b", pay);
        end
        check_idle("b2b_end", 4);
    endtask

    task automatic test_start_ignored();
        logic [191:0] pay;
        pay = rand_payload();
        run_frame(pay, 1'b1, 300, 0);
        check_frame("restart", pay);
        check_idle("restart_end", 12);
    endtask

    task automatic test_reset_midframe();
        logic [191:0] pay;
        logic [576:1] exp;
        pay = rand_payload();
        exp = model_frame(pay);
        run_frame(pay, 1'b1, 0, 250);
        checks++;
        if (got_vec[250:1] !== exp[250:1]) begin
            fails++;
            $display("FAIL abort_prefix: first mismatch at coded bit %0d",
                     first_diff({326'b0, got_vec[250:1]}, {326'b0, exp[250:1]}));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tif.coded_dat !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: coded_dat=%b expected 0", tif.coded_dat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("abort_idle", 5);
        pay = rand_payload();
        run_frame(pay, 1'b1, 0, 0);
        check_preamble("after_abort");
        check_frame("after_abort", pay);
        check_idle("after_abort_end", 4);
    endtask

    initial begin
        test_reset();
        test_zero_payload();
        test_pattern();
        test_back_to_back();
        test_start_ignored();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
